// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers completed results per functional unit and
// broadcasts one per cycle on a registered bus under round-robin priority.
module cdb_arbiter #(
    parameter int NUM_SRC    = 3,
    parameter int TAG_W      = 4,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 2,
    parameter logic [TAG_W-1:0] TAG_FREE = {TAG_W{1'b1}}
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    output logic [NUM_SRC-1:0]        src_ready,
    output logic                      CDB_valid,
    output logic [TAG_W-1:0]          CDB_tag,
    output logic [DATA_W-1:0]         CDB_data
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int RR_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int ENT_W = TAG_W + DATA_W;

    logic [ENT_W-1:0]  mem_q    [NUM_SRC][FIFO_DEPTH];
    logic [ENT_W-1:0]  mem_d    [NUM_SRC][FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q [NUM_SRC];
    logic [PTR_W-1:0]  wr_ptr_d [NUM_SRC];
    logic [PTR_W-1:0]  rd_ptr_q [NUM_SRC];
    logic [PTR_W-1:0]  rd_ptr_d [NUM_SRC];
    logic [CNT_W-1:0]  cnt_q    [NUM_SRC];
    logic [CNT_W-1:0]  cnt_d    [NUM_SRC];
    logic [RR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic              cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0] cdb_data_q, cdb_data_d;

    logic [NUM_SRC-1:0] push, pop;
    logic               found;
    logic [RR_W-1:0]    win;
    logic [ENT_W-1:0]   head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // src_valid/src_ready: a result transfers on every edge where both are high.
    // Ready depends only on registered occupancy, so a stalled source simply
    // holds valid and its payload until ready returns.
    always_comb begin
        src_ready = '0;
        push      = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_ready[i] = !rst && (cnt_q[i] < CNT_W'(FIFO_DEPTH));
            // A free-tag result is accepted but dropped so it can never reach the bus.
            push[i] = src_valid[i] && src_ready[i] &&
                      (src_tag[i*TAG_W +: TAG_W] != TAG_FREE);
        end
    end

    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            if (!found && (cnt_q[idx] != '0)) begin
                found = 1'b1;
                win   = RR_W'(idx);
            end
        end
        pop = '0;
        if (found) pop[win] = 1'b1;
        head = mem_q[win][rd_ptr_q[win]];
    end

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            wr_ptr_d[i] = wr_ptr_q[i];
            rd_ptr_d[i] = rd_ptr_q[i];
            cnt_d[i]    = cnt_q[i];
            for (int j = 0; j < FIFO_DEPTH; j++) mem_d[i][j] = mem_q[i][j];
            if (push[i]) begin
                mem_d[i][wr_ptr_q[i]] = {src_tag[i*TAG_W +: TAG_W], src_data[i*DATA_W +: DATA_W]};
                wr_ptr_d[i] = ptr_inc(wr_ptr_q[i]);
            end
            if (pop[i]) rd_ptr_d[i] = ptr_inc(rd_ptr_q[i]);
            case ({push[i], pop[i]})
                2'b10:   cnt_d[i] = cnt_q[i] + 1'b1;
                2'b01:   cnt_d[i] = cnt_q[i] - 1'b1;
                default: cnt_d[i] = cnt_q[i];
            endcase
        end

        cdb_valid_d = found;
        cdb_tag_d   = found ? head[ENT_W-1 -: TAG_W] : TAG_FREE;
        cdb_data_d  = found ? head[DATA_W-1:0] : '0;
        rr_ptr_d    = rr_ptr_q;
        if (found) rr_ptr_d = (win == RR_W'(NUM_SRC - 1)) ? '0 : win + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= TAG_FREE;
            cdb_data_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
        end
    end

    // Storage needs no reset: clearing the counts already discards every entry.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign CDB_valid = cdb_valid_q;
    assign CDB_tag   = cdb_tag_q;
    assign CDB_data  = cdb_data_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: queued per-source stimulus, per-source expected queues
// matched against every broadcast, plus an occupancy model for src_ready.
module tb_cdb_arbiter;
    localparam int NUM_SRC    = 3;
    localparam int TAG_W      = 4;
    localparam int DATA_W     = 32;
    localparam int FIFO_DEPTH = 2;
    localparam int ENT_W      = TAG_W + DATA_W;
    localparam logic [TAG_W-1:0] TAG_FREE = 4'b1111;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [NUM_SRC-1:0]        src_valid = '0;
    logic [NUM_SRC*TAG_W-1:0]  src_tag   = '0;
    logic [NUM_SRC*DATA_W-1:0] src_data  = '0;
    logic [NUM_SRC-1:0]        src_ready;
    logic                      CDB_valid;
    logic [TAG_W-1:0]          CDB_tag;
    logic [DATA_W-1:0]         CDB_data;

    cdb_arbiter #(
        .NUM_SRC(NUM_SRC), .TAG_W(TAG_W), .DATA_W(DATA_W),
        .FIFO_DEPTH(FIFO_DEPTH), .TAG_FREE(TAG_FREE)
    ) dut (
        .clk(clk), .rst(rst),
        .src_valid(src_valid), .src_tag(src_tag), .src_data(src_data),
        .src_ready(src_ready),
        .CDB_valid(CDB_valid), .CDB_tag(CDB_tag), .CDB_data(CDB_data)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_bcast  = 0;
    int stall2   = 0;
    logic [ENT_W-1:0] exp_q  [NUM_SRC][$];
    logic [ENT_W-1:0] send_q [NUM_SRC][$];
    logic [NUM_SRC-1:0] en     = '0;
    logic [NUM_SRC-1:0] acc    = '0;
    logic [NUM_SRC-1:0] pushed = '0;
    int occ      [NUM_SRC];
    int push_cyc [NUM_SRC];
    bit fair_mode = 0, lat_mode = 0, cons_mode = 0, have_last = 0;
    int last_src = NUM_SRC - 1;
    int last_bc_cyc = 0;
    logic [ENT_W-1:0] eng_item;
    logic [ENT_W-1:0] mon_item;
    logic [NUM_SRC-1:0] exp_ready;
    int found_src;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Handshake seen at the previous falling edge completes on this rising edge.
    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (acc[i] && send_q[i].size() > 0) begin
                eng_item = send_q[i].pop_front();
                if (eng_item[ENT_W-1 -: TAG_W] != TAG_FREE) begin
                    exp_q[i].push_back(eng_item);
                    pushed[i]   = 1'b1;
                    push_cyc[i] = cyc;
                end
            end
        end
        acc = '0;
        #1;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (en[i] && send_q[i].size() > 0) begin
                eng_item = send_q[i][0];
                src_valid[i] = 1'b1;
                src_tag[i*TAG_W +: TAG_W]    = eng_item[ENT_W-1 -: TAG_W];
                src_data[i*DATA_W +: DATA_W] = eng_item[DATA_W-1:0];
            end else begin
                src_valid[i] = 1'b0;
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        acc = src_valid & src_ready;
        if (!rst && src_valid[2] && !src_ready[2]) stall2++;
        for (int i = 0; i < NUM_SRC; i++) if (pushed[i]) occ[i]++;
        pushed = '0;
        found_src = -1;
        if (CDB_valid) begin
            n_bcast++;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (found_src < 0 && exp_q[i].size() > 0) begin
                    mon_item = exp_q[i][0];
                    if (mon_item == {CDB_tag, CDB_data}) found_src = i;
                end
            end
            check($sformatf("cdb_match tag=%0h data=%0h", CDB_tag, CDB_data), found_src >= 0, 1);
            if (found_src >= 0) begin
                void'(exp_q[found_src].pop_front());
                occ[found_src]--;
                if (fair_mode) check("rr_order", found_src, (last_src + 1) % NUM_SRC);
                last_src = found_src;
                if (lat_mode) check("latency", cyc - push_cyc[found_src], 1);
                if (cons_mode) begin
                    if (have_last) check("consecutive", cyc - last_bc_cyc, 1);
                    have_last   = 1;
                    last_bc_cyc = cyc;
                end
            end
        end else begin
            check("idle_tag", CDB_tag, TAG_FREE);
            check("idle_data", CDB_data, 0);
        end
        for (int i = 0; i < NUM_SRC; i++) exp_ready[i] = !rst && (occ[i] < FIFO_DEPTH);
        check("src_ready", src_ready, exp_ready);
    end

    // ---------------- helper tasks ----------------
    task automatic send(input int s, input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data);
        send_q[s].push_back({tag, data});
    endtask

    function automatic bit busy();
        bit b = 0;
        for (int i = 0; i < NUM_SRC; i++)
            if (send_q[i].size() > 0 || exp_q[i].size() > 0) b = 1;
        return b;
    endfunction

    task automatic drain(input int max_cyc);
        int n = 0;
        while (busy() && n < max_cyc) begin
            @(posedge clk);
            n++;
        end
        check("drain_timeout", n < max_cyc, 1);
        repeat (3) @(posedge clk);
        for (int i = 0; i < NUM_SRC; i++) check("left_in_scoreboard", exp_q[i].size(), 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_cdb_valid", CDB_valid, 0);
        check("rst_cdb_tag", CDB_tag, TAG_FREE);
        check("rst_cdb_data", CDB_data, 0);
        check("rst_src_ready", src_ready, 0);
        for (int i = 0; i < NUM_SRC; i++) begin
            exp_q[i].delete();
            send_q[i].delete();
            occ[i] = 0;
        end
        en       = '0;
        pushed   = '0;
        last_src = NUM_SRC - 1;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int b0;
        do_reset();
        repeat (3) @(posedge clk);
        check("post_reset_bcast", n_bcast, 0);

        // single result from the branch unit, latency and one-cycle pulse
        @(posedge clk); #2;
        b0 = n_bcast;
        lat_mode = 1;
        send(1, 4'd3, 32'hDEADBEEF);
        en = 3'b010;
        drain(20);
        lat_mode = 0;
        check("single_bcast_count", n_bcast - b0, 1);

        // free tag is consumed and never broadcast
        b0 = n_bcast;
        send(0, TAG_FREE, 32'd7);
        en = 3'b001;
        repeat (6) @(posedge clk);
        check("free_tag_consumed", send_q[0].size(), 0);
        check("free_tag_no_bcast", n_bcast - b0, 0);

        // fairness: all three sources saturated
        do_reset();
        b0 = n_bcast;
        for (int k = 0; k < 12; k++)
            for (int s = 0; s < NUM_SRC; s++)
                send(s, 4'(s + 1), 32'hA000_0000 | (s << 8) | k);
        fair_mode = 1;
        en = 3'b111;
        drain(200);
        fair_mode = 0;
        check("fair_bcast_count", n_bcast - b0, 36);

        // full FIFO backpressure on the load/store unit
        do_reset();
        stall2 = 0;
        for (int k = 0; k < 6; k++) begin
            send(0, 4'd7, 32'hB000_0000 | k);
            send(1, 4'd8, 32'hB100_0000 | k);
        end
        send(2, 4'd4, 32'hC000_0004);
        send(2, 4'd5, 32'hC000_0005);
        send(2, 4'd6, 32'hC000_0006);
        en = 3'b111;
        drain(200);
        check("src2_stalled", stall2 > 0, 1);

        // pointer wrap-around, single source at full rate
        @(posedge clk); #2;
        b0 = n_bcast;
        cons_mode = 1;
        have_last = 0;
        for (int k = 0; k < 10; k++) send(0, 4'(k), 32'hD000_0000 + k);
        en = 3'b001;
        drain(50);
        cons_mode = 0;
        check("wrap_bcast_count", n_bcast - b0, 10);

        // reset in the middle of a burst with entries still queued
        @(posedge clk); #2;
        send(0, 4'd1, 32'hE000_0000);
        send(0, 4'd2, 32'hE000_0001);
        send(1, 4'd3, 32'hE100_0000);
        send(1, 4'd4, 32'hE100_0001);
        en = 3'b011;
        repeat (2) @(posedge clk);
        do_reset();
        b0 = n_bcast;
        repeat (6) @(posedge clk);
        #1;
        check("no_bcast_after_reset", n_bcast - b0, 0);
        check("ready_after_reset", src_ready, 3'b111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
